// File: rtl/plru4_state_tracker.sv
// Per-set 4-way tree pseudo-LRU state tracker with a sequential invalidate-all sweep.
// Optional same-cycle touch forwarding to the query outputs: define PLRU4_TOUCH_BYPASS_EN.
module plru4_state_tracker #(
  parameter  int N_SETS = 8,
  localparam int SET_W  = (N_SETS > 1) ? $clog2(N_SETS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_touch_valid,
  input  logic [SET_W-1:0] io_touch_set,
  input  logic [1:0]       io_touch_way,
  input  logic [SET_W-1:0] io_query_set,
  output logic [2:0]       io_victim_state,
  output logic [1:0]       io_victim_way,
  input  logic             io_invalidate_all,
  output logic             io_busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic [2:0]       plru_q [N_SETS];
  logic [2:0]       plru_d [N_SETS];
  logic             touch_set_ok;
  logic             query_set_ok;
  logic [2:0]       sel_state;

  // State bits are {b2 root, b1 ways 0-1, b0 ways 2-3}; each points away from the touched way.
  function automatic logic [2:0] touch_update(input logic [2:0] cur, input logic [1:0] way);
    logic [2:0] nxt;
    nxt    = cur;
    nxt[2] = ~way[1];
    if (way[1]) nxt[0] = ~way[0];
    else        nxt[1] = ~way[0];
    return nxt;
  endfunction

  assign touch_set_ok = (32'(io_touch_set) < N_SETS);
  assign query_set_ok = (32'(io_query_set) < N_SETS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    plru_d  = plru_q;
    case (state_q)
      IDLE: begin
        if (io_invalidate_all) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (io_touch_valid && touch_set_ok) begin
          plru_d[io_touch_set] = touch_update(plru_q[io_touch_set], io_touch_way);
        end
      end
      SWEEP: begin
        plru_d[cnt_q] = '0;
        if (io_invalidate_all) begin
          cnt_d = '0;
        end else if (cnt_q == SET_W'(N_SETS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < N_SETS; i++) plru_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plru_q  <= plru_d;
    end
  end

  always_comb begin
    sel_state = '0;
    if (query_set_ok) sel_state = plru_q[io_query_set];
`ifdef PLRU4_TOUCH_BYPASS_EN
    // Forward only when the touch will actually commit at the next edge.
    if ((state_q == IDLE) && io_touch_valid && !io_invalidate_all && touch_set_ok &&
        (io_touch_set == io_query_set)) begin
      sel_state = touch_update(plru_q[io_query_set], io_touch_way);
    end
`endif
  end

  assign io_victim_state = sel_state;
  assign io_victim_way   = sel_state[2] ? {1'b1, sel_state[0]} : {1'b0, sel_state[1]};
  assign io_busy         = (state_q == SWEEP);

endmodule

// File: tb/tb_plru4_state_tracker.sv
// Directed bench for plru4_state_tracker: 8-set main instance plus a 6-set instance
// for out-of-range set indices; expectations flow through a scoreboard queue.
module tb_plru4_state_tracker;

`ifdef PLRU4_TOUCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       t_valid, inv;
  logic [2:0] t_set, q_set;
  logic [1:0] t_way;
  logic [2:0] v_state;
  logic [1:0] v_way;
  logic       busy;

  logic       t6_valid, inv6;
  logic [2:0] t6_set, q6_set;
  logic [1:0] t6_way;
  logic [2:0] v6_state;
  logic [1:0] v6_way;
  logic       busy6;

  plru4_state_tracker #(.N_SETS(8)) dut (
    .clock(clk), .reset(rst),
    .io_touch_valid(t_valid), .io_touch_set(t_set), .io_touch_way(t_way),
    .io_query_set(q_set), .io_victim_state(v_state), .io_victim_way(v_way),
    .io_invalidate_all(inv), .io_busy(busy)
  );

  plru4_state_tracker #(.N_SETS(6)) dut6 (
    .clock(clk), .reset(rst),
    .io_touch_valid(t6_valid), .io_touch_set(t6_set), .io_touch_way(t6_way),
    .io_query_set(q6_set), .io_victim_state(v6_state), .io_victim_way(v6_way),
    .io_invalidate_all(inv6), .io_busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    bit         six;
    logic [2:0] st;
    logic [1:0] way;
    logic       busy;
  } exp_t;

  exp_t       sbq[$];
  int         n_pass = 0;
  int         n_chk  = 0;
  logic [2:0] mdl [8];

  function automatic logic [2:0] mupd(input logic [2:0] s, input int w);
    case (w)
      0:       return {2'b11, s[0]};
      1:       return {2'b10, s[0]};
      2:       return {1'b0, s[1], 1'b1};
      default: return {1'b0, s[1], 1'b0};
    endcase
  endfunction

  function automatic logic [1:0] mvic(input logic [2:0] s);
    if (s[2]) return (s[0] ? 2'd3 : 2'd2);
    return (s[1] ? 2'd1 : 2'd0);
  endfunction

  task automatic push(input string tag, input bit six, input logic [2:0] st, input logic b);
    exp_t e;
    e.tag = tag; e.six = six; e.st = st; e.way = mvic(st); e.busy = b;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t       e;
    logic [2:0] os;
    logic [1:0] ow;
    logic       ob;
    while (sbq.size() > 0) begin
      e  = sbq.pop_front();
      os = e.six ? v6_state : v_state;
      ow = e.six ? v6_way   : v_way;
      ob = e.six ? busy6    : busy;
      n_chk++;
      assert (os === e.st) n_pass++;
      else $error("FAIL %s state observed=%b expected=%b", e.tag, os, e.st);
      n_chk++;
      assert (ow === e.way) n_pass++;
      else $error("FAIL %s way observed=%0d expected=%0d", e.tag, ow, e.way);
      n_chk++;
      assert (ob === e.busy) n_pass++;
      else $error("FAIL %s busy observed=%b expected=%b", e.tag, ob, e.busy);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int s, input int w, input int q, input logic iv);
    t_valid = v; t_set = 3'(s); t_way = 2'(w); q_set = 3'(q); inv = iv;
  endtask

  task automatic touch_cycle(input int s, input int w, input int q, input string tag);
    logic [2:0] e;
    tick();
    drive(1'b1, s, w, q, 1'b0);
    @(negedge clk);
    e = (BYP && (s == q)) ? mupd(mdl[s], w) : mdl[q];
    push(tag, 1'b0, e, 1'b0);
    pop_cmp();
    mdl[s] = mupd(mdl[s], w);
  endtask

  task automatic idle_cycle(input int q, input string tag);
    tick();
    drive(1'b0, 0, 0, q, 1'b0);
    @(negedge clk);
    push(tag, 1'b0, mdl[q], 1'b0);
    pop_cmp();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    t6_valid = 1'b0; t6_set = '0; t6_way = '0; q6_set = '0; inv6 = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;

    for (int q = 0; q < 8; q++) begin
      q_set = 3'(q);
      #1;
      push("reset_q", 1'b0, 3'b000, 1'b0);
      pop_cmp();
    end
    tick();
    rst = 1'b0;

    // Set 3 walk plus back-to-back touches on one set
    touch_cycle(3, 0, 3, "s3_w0");
    touch_cycle(3, 2, 3, "s3_w2");
    touch_cycle(3, 1, 3, "s3_w1");
    idle_cycle(3, "s3_final");
    touch_cycle(5, 3, 2, "s5_q2");
    idle_cycle(2, "s2_untouched");
    touch_cycle(4, 0, 4, "s4_samecyc");
    idle_cycle(4, "s4_next");

    for (int k = 0; k < 8; k++) touch_cycle(k, k % 3, k, "load");

    // Invalidate pulse with a same-cycle touch that must be dropped
    tick();
    drive(1'b1, 0, 3, 0, 1'b1);
    @(negedge clk);
    push("inv_pulse", 1'b0, mdl[0], 1'b0);
    pop_cmp();
    for (int c = 0; c < 8; c++) begin
      tick();
      drive(1'b1, 7, 3, c, 1'b0);
      @(negedge clk);
      push("sweep_old", 1'b0, mdl[c], 1'b1);
      pop_cmp();
      if (c > 0) begin
        q_set = 3'(c - 1);
        #1;
        push("sweep_clr", 1'b0, 3'b000, 1'b1);
        pop_cmp();
      end
      mdl[c] = '0;
    end
    idle_cycle(7, "sweep_done7");
    q_set = 3'd0;
    #1;
    push("sweep_done0", 1'b0, 3'b000, 1'b0);
    pop_cmp();

    // Restart pulse in the 4th busy cycle stretches busy to 12 cycles
    touch_cycle(6, 0, 6, "ld6");
    touch_cycle(7, 2, 7, "ld7");
    tick();
    drive(1'b0, 0, 0, 6, 1'b1);
    @(negedge clk);
    push("restart_pulse", 1'b0, 3'b110, 1'b0);
    pop_cmp();
    for (int i = 1; i <= 13; i++) begin
      tick();
      drive(1'b0, 0, 0, 6, (i == 4));
      @(negedge clk);
      push("restart_busy", 1'b0, (i >= 12) ? 3'b000 : 3'b110, (i <= 12));
      pop_cmp();
    end
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    idle_cycle(7, "restart_s7");

    // Reset in the middle of a sweep
    touch_cycle(5, 0, 5, "ld5");
    touch_cycle(7, 0, 7, "ld7b");
    tick();
    drive(1'b0, 0, 0, 7, 1'b1);
    @(negedge clk);
    push("rst_pulse", 1'b0, 3'b110, 1'b0);
    pop_cmp();
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive(1'b0, 0, 0, 7, 1'b0);
      @(negedge clk);
      push("rst_sweep", 1'b0, 3'b110, 1'b1);
      pop_cmp();
    end
    rst = 1'b1;
    #1;
    for (int q = 0; q < 8; q++) begin
      q_set = 3'(q);
      #1;
      push("rst_mid", 1'b0, 3'b000, 1'b0);
      pop_cmp();
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    idle_cycle(5, "post_rst5");
    touch_cycle(1, 3, 1, "post_rst_t");
    idle_cycle(1, "post_rst_v");

    // Out-of-range set indices on the 6-set instance
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    t6_valid = 1'b1; t6_set = 3'd5; t6_way = 2'd0; q6_set = 3'd5;
    @(negedge clk);
    push("n6_s5", 1'b1, BYP ? 3'b110 : 3'b000, 1'b0);
    pop_cmp();
    tick();
    t6_valid = 1'b1; t6_set = 3'd7; t6_way = 2'd0; q6_set = 3'd7;
    @(negedge clk);
    push("n6_q7", 1'b1, 3'b000, 1'b0);
    pop_cmp();
    q6_set = 3'd5;
    #1;
    push("n6_s5_reg", 1'b1, 3'b110, 1'b0);
    pop_cmp();
    tick();
    t6_valid = 1'b1; t6_set = 3'd6; t6_way = 2'd2; q6_set = 3'd6;
    @(negedge clk);
    push("n6_q6", 1'b1, 3'b000, 1'b0);
    pop_cmp();
    tick();
    t6_valid = 1'b0;
    @(negedge clk);
    q6_set = 3'd5;
    #1;
    push("n6_s5_hold", 1'b1, 3'b110, 1'b0);
    pop_cmp();
    q6_set = 3'd7;
    #1;
    push("n6_q7_after", 1'b1, 3'b000, 1'b0);
    pop_cmp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
